// File: rtl/ppu_posit_decode_stage_if.sv
// ppu_posit_decode_stage_if: operand-in / FIR-out handshake bundle of the posit decode stage.
// PPU_DECODE_STATS_EN adds the zero/NaR beat counter outputs.
interface ppu_posit_decode_stage_if #(
   parameter int N = 16,
   parameter int ES = 1,
   parameter int OP_SIZE = 3
);
   localparam int FIR_SIZE = 1 + ES + $clog2(N) + 2 + N - 2;
   logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, is_zero_o, is_nar_o;
   logic [N-1:0] posit_i;
   logic [OP_SIZE-1:0] op_i, op_o;
   logic [FIR_SIZE-1:0] fir_o;
`ifdef PPU_DECODE_STATS_EN
   logic [15:0] nar_cnt_o, zero_cnt_o;
   modport master (output in_valid_i, posit_i, op_i, out_ready_i,
                   input in_ready_o, out_valid_o, fir_o, is_zero_o, is_nar_o, op_o, nar_cnt_o, zero_cnt_o);
   modport slave (input in_valid_i, posit_i, op_i, out_ready_i,
                  output in_ready_o, out_valid_o, fir_o, is_zero_o, is_nar_o, op_o, nar_cnt_o, zero_cnt_o);
`else
   modport master (output in_valid_i, posit_i, op_i, out_ready_i,
                   input in_ready_o, out_valid_o, fir_o, is_zero_o, is_nar_o, op_o);
   modport slave (input in_valid_i, posit_i, op_i, out_ready_i,
                  output in_ready_o, out_valid_o, fir_o, is_zero_o, is_nar_o, op_o);
`endif
endinterface

// File: rtl/ppu_posit_decode_stage.sv
// ppu_posit_decode_stage: two-stage posit -> FIR {sign, te, mant} decoder with full back-pressure.
// Define PPU_DECODE_STATS_EN for saturating zero/NaR beat counters.
module ppu_posit_decode_stage #(
   parameter int N = 16,
   parameter int ES = 1,
   parameter int OP_SIZE = 3
) (
   input logic clk_i,
   input logic rstn_i,
   ppu_posit_decode_stage_if.slave bus
);
   localparam int S = $clog2(N);
   localparam int TE_SIZE = ES + S + 2;
   localparam int MS = N - 2;
   localparam int FIR_SIZE = 1 + TE_SIZE + MS;
   logic s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d, s1_nar_q, s1_nar_d;
   logic [N-2:0] s1_u_q, s1_u_d;
   logic [OP_SIZE-1:0] s1_op_q, s1_op_d, s2_op_q, s2_op_d;
   logic s2_valid_q, s2_valid_d, s2_zero_q, s2_zero_d, s2_nar_q, s2_nar_d;
   logic [FIR_SIZE-1:0] s2_fir_q, s2_fir_d, fir;
   logic s1_adv, s2_adv, s1_load, s2_load, r0, run;
   int m;
   logic [N-2:0] rem, frac_w;
   logic [MS-2:0] frac;
   logic [ES-1:0] expo;
   logic signed [TE_SIZE-1:0] k, te;
   // Regime run length m, then exponent and fraction left-aligned from the bits past the terminator.
   always_comb begin
      r0 = s1_u_q[N-2];
      m = 0;
      run = 1'b1;
      for (int i = N-2; i >= 0; i--) begin
         run = run && (s1_u_q[i] == r0);
         m = m + (run ? 1 : 0);
      end
      rem = s1_u_q << (m + 1);
      expo = ES'(rem >> (N - 1 - ES));
      frac_w = rem << ES;
      frac = (MS-1)'(frac_w >> 2);
      k = r0 ? TE_SIZE'(m - 1) : TE_SIZE'(-m);
      te = (k <<< ES) + TE_SIZE'(expo);
      fir = {s1_sign_q, te, 1'b1, frac};
   end
   always_comb begin
      s2_adv = !s2_valid_q || bus.out_ready_i;
      s1_adv = !s1_valid_q || s2_adv;
      s1_load = s1_adv && bus.in_valid_i;
      s2_load = s2_adv && s1_valid_q;
      s1_valid_d = s1_adv ? bus.in_valid_i : s1_valid_q;
      s1_sign_d = s1_load ? bus.posit_i[N-1] : s1_sign_q;
      s1_u_d = s1_load ? (N-1)'(bus.posit_i[N-1] ? -bus.posit_i : bus.posit_i) : s1_u_q;
      s1_zero_d = s1_load ? (bus.posit_i == '0) : s1_zero_q;
      s1_nar_d = s1_load ? (bus.posit_i == {1'b1, {(N-1){1'b0}}}) : s1_nar_q;
      s1_op_d = s1_load ? bus.op_i : s1_op_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      s2_fir_d = s2_load ? ((s1_zero_q || s1_nar_q) ? {s1_nar_q, {(FIR_SIZE-1){1'b0}}} : fir) : s2_fir_q;
      s2_zero_d = s2_load ? s1_zero_q : s2_zero_q;
      s2_nar_d = s2_load ? s1_nar_q : s2_nar_q;
      s2_op_d = s2_load ? s1_op_q : s2_op_q;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_valid_q <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_u_q <= '0;
         s1_zero_q <= 1'b0;
         s1_nar_q <= 1'b0;
         s1_op_q <= '0;
         s2_valid_q <= 1'b0;
         s2_fir_q <= '0;
         s2_zero_q <= 1'b0;
         s2_nar_q <= 1'b0;
         s2_op_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q <= s1_sign_d;
         s1_u_q <= s1_u_d;
         s1_zero_q <= s1_zero_d;
         s1_nar_q <= s1_nar_d;
         s1_op_q <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         s2_fir_q <= s2_fir_d;
         s2_zero_q <= s2_zero_d;
         s2_nar_q <= s2_nar_d;
         s2_op_q <= s2_op_d;
      end
   end
   assign bus.in_ready_o = s1_adv;
   assign bus.out_valid_o = s2_valid_q;
   assign bus.fir_o = s2_fir_q;
   assign bus.is_zero_o = s2_zero_q;
   assign bus.is_nar_o = s2_nar_q;
   assign bus.op_o = s2_op_q;
`ifdef PPU_DECODE_STATS_EN
   logic [15:0] nar_cnt_q, nar_cnt_d, zero_cnt_q, zero_cnt_d;
   logic take;
   always_comb begin
      take = s2_valid_q && bus.out_ready_i;
      nar_cnt_d = (take && s2_nar_q && !(&nar_cnt_q)) ? nar_cnt_q + 16'd1 : nar_cnt_q;
      zero_cnt_d = (take && s2_zero_q && !(&zero_cnt_q)) ? zero_cnt_q + 16'd1 : zero_cnt_q;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         nar_cnt_q <= '0;
         zero_cnt_q <= '0;
      end else begin
         nar_cnt_q <= nar_cnt_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end
   assign bus.nar_cnt_o = nar_cnt_q;
   assign bus.zero_cnt_o = zero_cnt_q;
`endif
endmodule

// File: tb/tb_ppu_posit_decode_stage.sv
// tb_ppu_posit_decode_stage: directed vectors for the posit decode stage (N=16, ES=1).
module tb_ppu_posit_decode_stage;
   logic clk = 1'b0;
   logic rstn;
   int n_cmp = 0;
   int n_err = 0;
   localparam logic [21:0] F4000 = {1'b0, 7'h00, 14'h2000};
   localparam logic [21:0] F5000 = {1'b0, 7'h01, 14'h2000};
   localparam logic [21:0] F3000 = {1'b0, 7'h7F, 14'h2000};
   localparam logic [21:0] F4800 = {1'b0, 7'h00, 14'h3000};
   localparam logic [21:0] FC000 = {1'b1, 7'h00, 14'h2000};
   localparam logic [21:0] F7FFF = {1'b0, 7'd28, 14'h2000};
   localparam logic [21:0] FNAR = 22'h200000;
   always #5 clk = ~clk;
   ppu_posit_decode_stage_if #(.N(16), .ES(1), .OP_SIZE(3)) bus ();
   ppu_posit_decode_stage #(.N(16), .ES(1), .OP_SIZE(3)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [15:0] p, input logic [2:0] op);
      bus.in_valid_i = v;
      bus.posit_i = p;
      bus.op_i = op;
   endtask
   task automatic chk_beat(input string tag, input logic [21:0] fir, input logic z, input logic n, input logic [2:0] op);
      chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
      chk({tag, "_fir"}, 32'(bus.fir_o), 32'(fir));
      chk({tag, "_zero"}, 32'(bus.is_zero_o), 32'(z));
      chk({tag, "_nar"}, 32'(bus.is_nar_o), 32'(n));
      chk({tag, "_op"}, 32'(bus.op_o), 32'(op));
   endtask
   initial begin
      rstn = 1'b0;
      bus.out_ready_i = 1'b1;
      drive(1'b0, 16'h0000, 3'd0);
      #12;
      chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_fir", 32'(bus.fir_o), 32'd0);
      rstn = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      drive(1'b1, 16'h4000, 3'd0);
      tick();
      drive(1'b0, 16'h0000, 3'd0);
      chk("one_lat1", 32'(bus.out_valid_o), 32'd0);
      tick();
      chk_beat("one", F4000, 1'b0, 1'b0, 3'd0);
      drive(1'b1, 16'h5000, 3'd1);
      tick();
      drive(1'b1, 16'h3000, 3'd2);
      tick();
      chk_beat("b2b_5000", F5000, 1'b0, 1'b0, 3'd1);
      drive(1'b1, 16'h4800, 3'd3);
      tick();
      chk_beat("b2b_3000", F3000, 1'b0, 1'b0, 3'd2);
      drive(1'b0, 16'h0000, 3'd0);
      tick();
      chk_beat("b2b_4800", F4800, 1'b0, 1'b0, 3'd3);
      tick();
      chk("b2b_drain", 32'(bus.out_valid_o), 32'd0);
      drive(1'b1, 16'hC000, 3'd4);
      tick();
      drive(1'b1, 16'h7FFF, 3'd5);
      tick();
      chk_beat("neg_one", FC000, 1'b0, 1'b0, 3'd4);
      drive(1'b0, 16'h0000, 3'd0);
      tick();
      chk_beat("maxpos", F7FFF, 1'b0, 1'b0, 3'd5);
      drive(1'b1, 16'h0000, 3'd1);
      tick();
      drive(1'b1, 16'h8000, 3'd2);
      tick();
      chk_beat("zero", 22'h0, 1'b1, 1'b0, 3'd1);
      drive(1'b0, 16'h0000, 3'd0);
      tick();
      chk_beat("nar", FNAR, 1'b0, 1'b1, 3'd2);
      tick();
      chk("nar_drain", 32'(bus.out_valid_o), 32'd0);
`ifdef PPU_DECODE_STATS_EN
      chk("zero_cnt", 32'(bus.zero_cnt_o), 32'd1);
      chk("nar_cnt", 32'(bus.nar_cnt_o), 32'd1);
`endif
      bus.out_ready_i = 1'b0;
      drive(1'b1, 16'h4000, 3'd0);
      #1;
      chk("bp_ready0", 32'(bus.in_ready_o), 32'd1);
      tick();
      chk("bp_ready1", 32'(bus.in_ready_o), 32'd1);
      drive(1'b1, 16'h5000, 3'd1);
      tick();
      chk_beat("bp_first", F4000, 1'b0, 1'b0, 3'd0);
      drive(1'b1, 16'h3000, 3'd2);
      #1;
      chk("bp_full", 32'(bus.in_ready_o), 32'd0);
      tick();
      chk_beat("bp_hold1", F4000, 1'b0, 1'b0, 3'd0);
      chk("bp_full1", 32'(bus.in_ready_o), 32'd0);
      tick();
      chk_beat("bp_hold2", F4000, 1'b0, 1'b0, 3'd0);
      bus.out_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready_o), 32'd1);
      tick();
      drive(1'b0, 16'h0000, 3'd0);
      chk_beat("bp_op1", F5000, 1'b0, 1'b0, 3'd1);
      tick();
      chk_beat("bp_op2", F3000, 1'b0, 1'b0, 3'd2);
      tick();
      chk("bp_drain", 32'(bus.out_valid_o), 32'd0);
      bus.out_ready_i = 1'b0;
      drive(1'b1, 16'h4000, 3'd3);
      tick();
      drive(1'b1, 16'h5000, 3'd4);
      tick();
      chk("ar_full_valid", 32'(bus.out_valid_o), 32'd1);
      chk("ar_full_ready", 32'(bus.in_ready_o), 32'd0);
      drive(1'b0, 16'h0000, 3'd0);
      rstn = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.out_valid_o), 32'd0);
      chk("ar_fir", 32'(bus.fir_o), 32'd0);
      chk("ar_op", 32'(bus.op_o), 32'd0);
`ifdef PPU_DECODE_STATS_EN
      chk("ar_zero_cnt", 32'(bus.zero_cnt_o), 32'd0);
      chk("ar_nar_cnt", 32'(bus.nar_cnt_o), 32'd0);
`endif
      #2;
      rstn = 1'b1;
      bus.out_ready_i = 1'b1;
      drive(1'b1, 16'h3000, 3'd5);
      tick();
      drive(1'b0, 16'h0000, 3'd0);
      chk("ar_lat1", 32'(bus.out_valid_o), 32'd0);
      tick();
      chk_beat("ar_new", F3000, 1'b0, 1'b0, 3'd5);
      tick();
      chk("ar_drain", 32'(bus.out_valid_o), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ppu_posit_decode_stage.md
Name: ppu_posit_decode_stage

Overview:
- Pipelined front-end of the PPU core.
- Converts an N-bit posit operand into the intermediate FIR form {sign, te, mant} that the arithmetic stages consume.
- Flags zero and NaR operands, and carries the operation code alongside the data.
- Two register stages with valid/ready handshaking and full back-pressure. Sits between the operand request interface and the add/sub/mul/div datapath.

Parameters:
- N, 16, posit width in bits (4..32).
- ES, 1, posit exponent-field width.
- OP_SIZE, 3, width of the op tag carried through unchanged.
- Derived, not overridable: S = clog2(N); TE_SIZE = ES+S+2; MS = N-2; FIR_SIZE = 1+TE_SIZE+MS.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  stage can accept a beat
- posit_i  in  N  posit operand
- op_i  in  OP_SIZE  operation tag (ADD=0 .. POSIT_TO_FLOAT=5)
- out_valid_o  out  1  decoded beat valid
- out_ready_i  in  1  downstream accepts
- fir_o  out  FIR_SIZE  {sign, te (signed, TE_SIZE), mant (MS)}
- is_zero_o  out  1  operand was 0
- is_nar_o  out  1  operand was NaR
- op_o  out  OP_SIZE  op tag of this beat

Interface: one clock, clk_i. Reset rstn_i is asynchronous and active-low.

Behaviour:
- Reset: all valid bits are 0, all data registers are 0, and out_valid_o=0. in_ready_o=1 after reset deasserts.
- A transfer occurs on the rising clk_i edge when valid&&ready on the same side.
- Stage 1 (S1) registers:
  - sign = posit_i[N-1]
  - u = sign ? two's complement of posit_i : posit_i
  - zero = (posit_i==0)
  - nar = (posit_i=={1,0...})
  - op
- Stage 2 (S2) decodes u:
  - r0 = u[N-2]; m = length of the run of r0 in u[N-2:0], range 1..N-1.
  - k = r0 ? m-1 : -m.
  - Regime occupies min(m+1, N-1) bits. The next ES bits are the exponent; bits past the LSB read as 0.
  - te = k*2^ES + exp, sign-extended to TE_SIZE.
  - mant: MSB is the hidden 1. The remaining fraction bits are left-aligned directly below it, zero-padded. Width is MS.
  - When zero or nar is set, fir_o = 0 except sign, which is 1 for NaR.
- Latency: 2 cycles from input acceptance to out_valid_o, with no bubbles when out_ready_i=1. Throughput is 1 beat/cycle.
- Handshake:
  - S2 advances when !s2_valid || out_ready_i.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready_o equals the S1 advance condition and is combinational from out_ready_i. No skid buffer.
- Hold rule: while out_valid_o=1 and out_ready_i=0, fir_o, is_zero_o, is_nar_o and op_o hold stable.
- Pipeline full (2 beats held): in_ready_o=0 until out_ready_i=1.
- Simultaneous accept-in/accept-out: pipeline occupancy stays constant. No beat is lost or duplicated, and order is preserved.
- Async reset mid-operation discards all in-flight beats immediately.

Optional Feature:
- Macro: PPU_DECODE_STATS_EN.
- Defined: adds outputs nar_cnt_o[15:0] and zero_cnt_o[15:0].
  - Each increments by 1 when an S2 beat with is_nar_o or is_zero_o is accepted downstream.
  - Counts saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent, and decode behaviour is identical.

Test Plan (N=16, ES=1):
- posit_i=16'h4000 (1.0), out_ready_i=1 -> 2 cycles later: sign=0, te=0, mant=14'h2000, flags=0.
- Back-to-back beats 16'h5000, 16'h3000, 16'h4800 -> te=1/mant 14'h2000, then te=-1/mant 14'h2000, then te=0/mant 14'h3000, on consecutive cycles.
- 16'hC000, then 16'h7FFF -> sign=1, te=0, mant 14'h2000; then te=28, mant 14'h2000.
- 16'h0000, then 16'h8000 -> is_zero_o=1 with fir_o=0; then is_nar_o=1 with sign=1 and te=0, mant=0. With PPU_DECODE_STATS_EN: zero_cnt_o=1, nar_cnt_o=1.
- Back-pressure: hold out_ready_i=0 and offer 3 beats with op_i=0,1,2:
  - Only 2 are accepted, then in_ready_o=0.
  - Outputs stay stable while stalled.
  - On release, ops emerge in order 0,1,2 with no duplicates.
- Assert rstn_i=0 with both stages full -> out_valid_o=0 immediately. After release, the first new beat appears after exactly 2 cycles.
